flex_fifo_ctrl: RTL and testbench

Single-clock FIFO controller that drives flex_fifo_mem's write port and read address, and returns read data to the consumer.
- Generates write enable/address and read address, plus full/empty/count/almost-full status.
- Sits between the JTAG shift/capture logic (producer, push side) and the bus-side consumer (pop side).
- Memory read is combinational, so pop_data is first-word-fall-through: valid whenever empty=0.

---
 rtl/jtag_types_pkg.sv | 10 +
 rtl/flex_fifo_ptr.sv | 25 ++
 rtl/flex_fifo_ctrl.sv | 85 ++++++++
 tb/tb_flex_fifo_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/jtag_types_pkg.sv
// rtl/jtag_types_pkg.sv - shared FIFO widths and pointer/data types
package jtag_types_pkg;

    localparam int FIFO_DATA_W = 8;
    localparam int FIFO_ADDR_W = 4;

    typedef logic [FIFO_ADDR_W:0]   fifo_ptr_t;
    typedef logic [FIFO_DATA_W-1:0] fifo_data_t;

endpackage

// File: rtl/flex_fifo_ptr.sv
// rtl/flex_fifo_ptr.sv - wrap-bit FIFO pointer register with increment and clear
module flex_fifo_ptr
    import jtag_types_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                inc,
    output logic [ADDR_WIDTH:0] ptr
);

    // Reset and clear both zero the pointer; otherwise advance, wrapping naturally through the MSB
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/flex_fifo_ctrl.sv
// rtl/flex_fifo_ctrl.sv - single-clock FIFO controller; optional FLEX_FIFO_CTRL_ERR_EN adds sticky overflow/underflow
module flex_fifo_ctrl
    import jtag_types_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_W,
    parameter int ADDR_WIDTH = FIFO_ADDR_W,
    parameter int AF_THRESH  = 2**ADDR_WIDTH - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef FLEX_FIFO_CTRL_ERR_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam logic [ADDR_WIDTH:0] AF_LEVEL  = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] WRAP_DIFF = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH:0] wptr;
    logic [ADDR_WIDTH:0] rptr;
    logic                push_ok;
    logic                pop_ok;

    // Reset also blocks the write strobe so nothing lands in memory during a reset cycle
    assign push_ok = push & ~full  & ~clear & ~rst;
    assign pop_ok  = pop  & ~empty & ~clear;

    flex_fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wptr (
        .clk (clk),
        .rst (rst),
        .clr (clear),
        .inc (push_ok),
        .ptr (wptr)
    );

    flex_fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rptr (
        .clk (clk),
        .rst (rst),
        .clr (clear),
        .inc (pop_ok),
        .ptr (rptr)
    );

    // Status is derived purely from the registered pointers
    assign count       = wptr - rptr;
    assign empty       = (wptr == rptr);
    assign full        = ((wptr ^ rptr) == WRAP_DIFF);
    assign almost_full = (count >= AF_LEVEL);

    assign mem_wen   = push_ok;
    assign mem_waddr = wptr[ADDR_WIDTH-1:0];
    assign mem_wdata = push_data;
    assign mem_raddr = rptr[ADDR_WIDTH-1:0];
    assign pop_data  = mem_rdata;

`ifdef FLEX_FIFO_CTRL_ERR_EN
    // Sticky error flags record dropped requests until reset or clear
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && full)  overflow  <= 1'b1;
            if (pop  && empty) underflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_flex_fifo_ctrl.sv
// tb/tb_flex_fifo_ctrl.sv - randomized and directed self-checking bench for flex_fifo_ctrl
module tb_flex_fifo_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int AFT   = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clear = 1'b0;
    logic          push = 1'b0;
    logic [DW-1:0] push_data = '0;
    logic          pop = 1'b0;
    logic [DW-1:0] pop_data;
    logic          full, empty, almost_full;
    logic [AW:0]   count;
    logic          mem_wen;
    logic [AW-1:0] mem_waddr, mem_raddr;
    logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef FLEX_FIFO_CTRL_ERR_EN
    logic          overflow, underflow;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    flex_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(AFT)) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .push        (push),
        .push_data   (push_data),
        .pop         (pop),
        .pop_data    (pop_data),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (count),
        .mem_wen     (mem_wen),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .mem_raddr   (mem_raddr),
        .mem_rdata   (mem_rdata)
`ifdef FLEX_FIFO_CTRL_ERR_EN
        ,
        .overflow    (overflow),
        .underflow   (underflow)
`endif
    );

    // Attached memory: synchronous write, combinational read
    logic [DW-1:0] mem [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    always @(posedge clk) if (mem_wen) mem[mem_waddr] <= mem_wdata;
    assign mem_rdata = mem[mem_raddr];

    // Behavioural reference: an ordered queue plus counts of accepted writes/reads
    logic [DW-1:0] q[$];
    int  wr_n = 0;
    int  rd_n = 0;
    bit  m_valid = 0;
    bit  m_ovf = 0;
    bit  m_unf = 0;

    always @(posedge clk) begin
        int sz;
        sz = q.size();
        if (rst) begin
            q.delete(); wr_n = 0; rd_n = 0; m_ovf = 0; m_unf = 0; m_valid = 1;
        end else if (clear) begin
            q.delete(); wr_n = 0; rd_n = 0; m_ovf = 0; m_unf = 0;
        end else begin
            if (push && sz == DEPTH) m_ovf = 1;
            if (pop && sz == 0)      m_unf = 1;
            if (pop && sz > 0) begin
                void'(q.pop_front()); rd_n++;
            end
            if (push && sz < DEPTH) begin
                q.push_back(push_data); wr_n++;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the reference, away from the active edge
    always @(negedge clk) begin
        if (m_valid) begin
            chk("count", int'(count), q.size());
            chk("empty", int'(empty), int'(q.size() == 0));
            chk("full", int'(full), int'(q.size() == DEPTH));
            chk("almost_full", int'(almost_full), int'(q.size() >= AFT));
            chk("mem_wen", int'(mem_wen), int'(push && !clear && !rst && q.size() < DEPTH));
            chk("mem_wdata", int'(mem_wdata), int'(push_data));
            chk("mem_waddr", int'(mem_waddr), wr_n % DEPTH);
            chk("mem_raddr", int'(mem_raddr), rd_n % DEPTH);
            if (q.size() > 0) chk("pop_data", int'(pop_data), int'(q[0]));
`ifdef FLEX_FIFO_CTRL_ERR_EN
            chk("overflow", int'(overflow), int'(m_ovf));
            chk("underflow", int'(underflow), int'(m_unf));
`endif
        end
    end

    task automatic drive(input bit r, input bit c, input bit pu, input logic [DW-1:0] d, input bit po);
        rst = r; clear = c; push = pu; push_data = d; pop = po;
        @(posedge clk); #1;
    endtask

    initial begin
        @(posedge clk); #1;
        drive(1, 0, 0, 8'h00, 0);
        drive(1, 0, 0, 8'h00, 0);
        drive(0, 0, 0, 8'h00, 0);
        chk("lit_reset_count", int'(count), 0);
        chk("lit_reset_empty", int'(empty), 1);
        chk("lit_reset_full", int'(full), 0);
        chk("lit_reset_af", int'(almost_full), 0);

        drive(0, 0, 1, 8'h11, 0);
        chk("lit_count1", int'(count), 1);
        chk("lit_head11", int'(pop_data), 8'h11);
        drive(0, 0, 1, 8'h22, 0);
        chk("lit_count2", int'(count), 2);
        chk("lit_af_at2", int'(almost_full), 0);
        drive(0, 0, 1, 8'h33, 0);
        chk("lit_count3", int'(count), 3);
        chk("lit_af_at3", int'(almost_full), 1);
        drive(0, 0, 1, 8'h44, 0);
        chk("lit_full", int'(full), 1);
        chk("lit_count4", int'(count), 4);

        push = 1; push_data = 8'h55; #2;
        chk("lit_wen_when_full", int'(mem_wen), 0);
        @(posedge clk); #1;
        push = 0;
        chk("lit_count_after_drop", int'(count), 4);
        begin
            logic [DW-1:0] exp_vals [4];
            exp_vals = '{8'h11, 8'h22, 8'h33, 8'h44};
            for (int i = 0; i < 4; i++) begin
                chk("lit_pop_order", int'(pop_data), int'(exp_vals[i]));
                drive(0, 0, 0, 8'h00, 1);
            end
        end
        chk("lit_empty_after_pops", int'(empty), 1);

        drive(0, 0, 0, 8'h00, 1);
        chk("lit_pop_empty_count", int'(count), 0);
        chk("lit_pop_empty_raddr", int'(mem_raddr), 0);
`ifdef FLEX_FIFO_CTRL_ERR_EN
        chk("lit_underflow", int'(underflow), 1);
`endif

        drive(0, 0, 1, 8'hB0, 0);
        drive(0, 0, 1, 8'hB1, 0);
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 1, 8'hA0 + 8'(i), 1);
            chk("lit_pushpop_count", int'(count), 2);
        end
        chk("lit_wrap_head", int'(pop_data), 8'hA4);

        drive(0, 0, 1, 8'hC0, 0);
        chk("lit_count3_pre_clear", int'(count), 3);
        rst = 0; clear = 1; push = 1; push_data = 8'hEE; pop = 0; #2;
        chk("lit_wen_on_clear", int'(mem_wen), 0);
        @(posedge clk); #1;
        clear = 0; push = 0;
        chk("lit_clear_count", int'(count), 0);
        chk("lit_clear_empty", int'(empty), 1);
`ifdef FLEX_FIFO_CTRL_ERR_EN
        chk("lit_clear_underflow", int'(underflow), 0);
`endif

        drive(0, 0, 1, 8'hD0, 0);
        drive(0, 0, 1, 8'hD1, 0);
        drive(1, 0, 1, 8'hD2, 0);
        chk("lit_rst_count", int'(count), 0);
        chk("lit_rst_empty", int'(empty), 1);
        drive(0, 0, 1, 8'h77, 0);
        push = 0;
        chk("lit_head77", int'(pop_data), 8'h77);
        chk("lit_count_after77", int'(count), 1);

        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 99) < 55), 8'($urandom), ($urandom_range(0, 99) < 45));
        end
        drive(0, 0, 0, 8'h00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
